// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between LSU, CSR and ALU; tracks pending loads for read hazards.
// Grants are combinational (one per cycle, losers hold their request); read correction adds no latency beyond the RF.
module reg_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lsu_wr_req_i,
    input  logic [4:0]      lsu_waddr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_wr_gnt_o,
    input  logic            csr_wr_req_i,
    input  logic [4:0]      csr_waddr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            csr_wr_gnt_o,
    input  logic            alu_wr_req_i,
    input  logic [4:0]      alu_waddr_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    output logic            alu_wr_gnt_o,
    input  logic            ld_issue_i,
    input  logic [4:0]      ld_rd_i,
    input  logic [4:0]      raddr_1_i,
    input  logic [4:0]      raddr_2_i,
    input  logic [XLEN-1:0] rf_rdata_1_i,
    input  logic [XLEN-1:0] rf_rdata_2_i,
    output logic            rf_wr_c_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic [XLEN-1:0] rdata_1_o,
    output logic [XLEN-1:0] rdata_2_o,
    output logic            hazard_1_o,
    output logic            hazard_2_o
);

    localparam int         NREQ = 3;
    localparam logic [4:0] LIM  = 5'(STARVE_LIM);

    // Requester index order doubles as the default priority: 0 = LSU, 1 = CSR, 2 = ALU.
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] promote;
    logic [NREQ-1:0] promo_req;
    logic [4:0]      waddr [NREQ];
    logic [XLEN-1:0] wdata [NREQ];
    logic [3:0]      starve_cnt [NREQ];

    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;

    logic [31:0]     pending;
    logic [31:0]     ld_set;
    logic [31:0]     ld_clr;

    logic            byp_vld_1;
    logic            byp_vld_2;
    logic [XLEN-1:0] byp_data;

    assign req      = {alu_wr_req_i, csr_wr_req_i, lsu_wr_req_i};
    assign waddr[0] = lsu_waddr_i;
    assign waddr[1] = csr_waddr_i;
    assign waddr[2] = alu_waddr_i;
    assign wdata[0] = lsu_wdata_i;
    assign wdata[1] = csr_wdata_i;
    assign wdata[2] = alu_wdata_i;

    // Promoted requesters form their own tier; default order breaks ties within each tier.
    always_comb begin
        gnt       = '0;
        promo_req = req & promote;
        if (reset) begin
            if (promo_req[0])      gnt = 3'b001;
            else if (promo_req[1]) gnt = 3'b010;
            else if (promo_req[2]) gnt = 3'b100;
            else if (req[0])       gnt = 3'b001;
            else if (req[1])       gnt = 3'b010;
            else if (req[2])       gnt = 3'b100;
        end
    end

    assign lsu_wr_gnt_o = gnt[0];
    assign csr_wr_gnt_o = gnt[1];
    assign alu_wr_gnt_o = gnt[2];

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | waddr[i];
                sel_data = sel_data | wdata[i];
            end
        end
    end

    assign rf_wr_c_o  = (|gnt) && (sel_addr != 5'd0);
    assign rf_waddr_o = sel_addr;
    assign rf_wdata_o = sel_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                starve_cnt[i] <= '0;
            end
            promote <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || gnt[i]) begin
                    starve_cnt[i] <= '0;
                end else if (starve_cnt[i] != 4'hF) begin
                    starve_cnt[i] <= starve_cnt[i] + 4'd1;
                end
                // Flag is raised on the same edge the counter reaches the limit.
                if (gnt[i]) begin
                    promote[i] <= 1'b0;
                end else if (req[i] && (({1'b0, starve_cnt[i]} + 5'd1) == LIM)) begin
                    promote[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ld_set = '0;
        ld_clr = '0;
        if (ld_issue_i) ld_set[ld_rd_i] = 1'b1;
        if (gnt[0])     ld_clr[lsu_waddr_i] = 1'b1;
    end

    // Set is OR'd after the clear so a back-to-back load to the same rd stays pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~ld_clr) | ld_set) & ~32'd1;
        end
    end

    assign hazard_1_o = pending[raddr_1_i] &&
                        !(gnt[0] && (lsu_waddr_i == raddr_1_i) && (raddr_1_i != 5'd0));
    assign hazard_2_o = pending[raddr_2_i] &&
                        !(gnt[0] && (lsu_waddr_i == raddr_2_i) && (raddr_2_i != 5'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp_vld_1 <= 1'b0;
            byp_vld_2 <= 1'b0;
            byp_data  <= '0;
        end else begin
            byp_vld_1 <= rf_wr_c_o && (rf_waddr_o == raddr_1_i);
            byp_vld_2 <= rf_wr_c_o && (rf_waddr_o == raddr_2_i);
            byp_data  <= rf_wdata_o;
        end
    end

    assign rdata_1_o = byp_vld_1 ? byp_data : rf_rdata_1_i;
    assign rdata_2_o = byp_vld_2 ? byp_data : rf_rdata_2_i;

endmodule
